// File: rtl/vga_anim_ctrl_if.sv
// Control/config bundle between the frame timing, board buttons and the animation sequencer.
// Latency: none (plain signal grouping).
// Backpressure: none; config outputs are level signals, cfg_update marks a new set.
// Ports (bundle members):
//   frame_start  - 1-cycle pulse at the first pixel of every frame
//   btn_*_n      - raw active-low board buttons (asynchronous)
//   offset, mode, palette_rot, speed, paused - per-frame config for the pixel datapath
//   cfg_update   - 1-cycle pulse on the cycle the config outputs changed
interface vga_anim_ctrl_if;
  logic        frame_start;
  logic        btn_pause_n;
  logic        btn_speed_n;
  logic        btn_mode_n;
  logic [31:0] offset;
  logic [1:0]  mode;
  logic [4:0]  palette_rot;
  logic [1:0]  speed;
  logic        paused;
  logic        cfg_update;

  // master: the sequencer (consumes timing/buttons, produces config)
  modport master (
    input  frame_start, btn_pause_n, btn_speed_n, btn_mode_n,
    output offset, mode, palette_rot, speed, paused, cfg_update
  );

  // slave: timing generator / board / datapath side
  modport slave (
    output frame_start, btn_pause_n, btn_speed_n, btn_mode_n,
    input  offset, mode, palette_rot, speed, paused, cfg_update
  );
endinterface

// File: rtl/vga_anim_ctrl.sv
// Frame-synchronous animation sequencer: debounced buttons drive run/pause, speed and mode.
// Latency: button press -> event 2+DEBOUNCE_CYCLES clk; frame_start -> new config next cycle.
// Backpressure: none; events are held as sticky pending flags until the next frame_start.
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous active-high reset
//   bus  - vga_anim_ctrl_if.master: frame_start and raw buttons in; offset, mode,
//          palette_rot, speed, paused and cfg_update out (all registered)
module vga_anim_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PAL_DIV         = 8,
  parameter int PAL_ENTRIES     = 18
) (
  input  logic           clk,
  input  logic           rst,
  vga_anim_ctrl_if.master bus
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW = (PAL_DIV > 1) ? $clog2(PAL_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(PAL_DIV - 1);
  localparam logic [4:0]    PAL_LAST = 5'(PAL_ENTRIES - 1);

  // Button index: 0 pause, 1 speed, 2 mode
  localparam int B_PAUSE = 0;
  localparam int B_SPEED = 1;
  localparam int B_MODE  = 2;

  typedef enum logic {
    ST_RUN,
    ST_PAUSED
  } state_t;

  logic [2:0]    btn_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    stable;
  logic [CW-1:0] db_cnt [3];
  logic [2:0]    press_evt;

  logic          pend_pause;
  logic          pend_speed;
  logic          pend_mode;

  state_t        state_q;
  state_t        state_d;
  logic          advance;
  logic [1:0]    speed_nx;

  logic [31:0]   offset_q;
  logic [1:0]    mode_q;
  logic [4:0]    pal_q;
  logic [1:0]    speed_q;
  logic [DW-1:0] div_q;
  logic          cfg_update_q;

  assign btn_raw = {bus.btn_mode_n, bus.btn_speed_n, bus.btn_pause_n};

  // Synchroniser + debouncer. Buttons are active-low, so '1' is the released state.
  // The counter runs only while the synced level disagrees with the stable level and
  // restarts whenever they agree again, so a bounce back restarts the stability window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Press event: the cycle in which stable is about to go released -> pressed
  always_comb begin
    press_evt = '0;
    for (int i = 0; i < 3; i++) begin
      press_evt[i] = stable[i] && !sync2[i] && (db_cnt[i] == CNT_LAST);
    end
  end

  // Pending flags. frame_start consumes what was pending before this cycle; an event
  // landing on the frame_start cycle itself survives for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_pause <= 1'b0;
      pend_speed <= 1'b0;
      pend_mode  <= 1'b0;
    end else if (bus.frame_start) begin
      pend_pause <= press_evt[B_PAUSE];
      pend_speed <= press_evt[B_SPEED];
      pend_mode  <= press_evt[B_MODE];
    end else begin
      pend_pause <= pend_pause | press_evt[B_PAUSE];
      pend_speed <= pend_speed | press_evt[B_SPEED];
      pend_mode  <= pend_mode  | press_evt[B_MODE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Run/pause decisions are made only on frame_start
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    if (bus.frame_start) begin
      case (state_q)
        ST_RUN: begin
          if (pend_pause) begin
            state_d = ST_PAUSED;
          end else begin
            advance = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (pend_pause) begin
            state_d = ST_RUN;
            advance = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // A speed change requested for this frame already applies to this frame's step
  assign speed_nx = pend_speed ? (speed_q + 2'd1) : speed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q     <= '0;
      mode_q       <= '0;
      pal_q        <= '0;
      speed_q      <= '0;
      div_q        <= '0;
      cfg_update_q <= 1'b0;
    end else begin
      cfg_update_q <= bus.frame_start;
      if (bus.frame_start) begin
        speed_q <= speed_nx;
        if (pend_mode) begin
          mode_q <= mode_q + 2'd1;
        end
        if (advance) begin
          offset_q <= offset_q + (32'd1 << speed_nx);
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            pal_q <= (pal_q == PAL_LAST) ? 5'd0 : (pal_q + 5'd1);
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
      end
    end
  end

  assign bus.offset      = offset_q;
  assign bus.mode        = mode_q;
  assign bus.palette_rot = pal_q;
  assign bus.speed       = speed_q;
  assign bus.paused      = (state_q == ST_PAUSED);
  assign bus.cfg_update  = cfg_update_q;

endmodule

// File: tb/tb_vga_anim_ctrl.sv
// Self-checking bench for vga_anim_ctrl: reference model + expected-config scoreboard.
// Latency: expectations pushed at each frame_start, popped on each cfg_update pulse.
// Backpressure: none; every frame_start must yield exactly one cfg_update.
module tb_vga_anim_ctrl;

  localparam int DEB  = 4;
  localparam int PDIV = 2;
  localparam int PENT = 18;

  typedef struct packed {
    logic [31:0] off;
    logic [1:0]  mode;
    logic [4:0]  pal;
    logic [1:0]  speed;
    logic        paused;
  } exp_t;

  logic clk;
  logic rst;

  vga_anim_ctrl_if bus ();

  vga_anim_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .PAL_DIV        (PDIV),
    .PAL_ENTRIES    (PENT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_frames = 0;
  int n_cfg    = 0;

  exp_t sb_q[$];

  // Reference model state
  int unsigned m_off;
  int          m_mode, m_pal, m_speed, m_div;
  bit          m_paused, m_pp, m_ps, m_pm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_off = 0; m_mode = 0; m_pal = 0; m_speed = 0; m_div = 0;
    m_paused = 0; m_pp = 0; m_ps = 0; m_pm = 0;
  endtask

  // Frame update as the behaviour describes it, then queue the expected config
  task automatic model_step();
    exp_t e;
    bit adv;
    adv = 0;
    if (!m_paused) begin
      if (m_pp) m_paused = 1;
      else      adv = 1;
    end else if (m_pp) begin
      m_paused = 0;
      adv = 1;
    end
    if (m_ps) m_speed = (m_speed + 1) % 4;
    if (m_pm) m_mode  = (m_mode + 1) % 4;
    if (adv) begin
      m_off = m_off + (32'd1 << m_speed);
      if (m_div == PDIV - 1) begin
        m_div = 0;
        m_pal = (m_pal == PENT - 1) ? 0 : m_pal + 1;
      end else begin
        m_div = m_div + 1;
      end
    end
    m_pp = 0; m_ps = 0; m_pm = 0;
    e.off    = m_off;
    e.mode   = 2'(m_mode);
    e.pal    = 5'(m_pal);
    e.speed  = 2'(m_speed);
    e.paused = m_paused;
    sb_q.push_back(e);
    n_frames++;
  endtask

  // Compare current outputs against the model (used between frames: nothing may move)
  task automatic check_now(input string tag);
    @(negedge clk);
    check_eq({tag, "_offset"}, bus.offset, m_off);
    check_eq({tag, "_mode"},   32'(bus.mode), m_mode);
    check_eq({tag, "_pal"},    32'(bus.palette_rot), m_pal);
    check_eq({tag, "_speed"},  32'(bus.speed), m_speed);
    check_eq({tag, "_paused"}, 32'(bus.paused), 32'(m_paused));
    check_eq({tag, "_cfgupd"}, 32'(bus.cfg_update), 0);
  endtask

  task automatic do_frame();
    @(posedge clk); #1;
    bus.frame_start = 1'b1;
    model_step();
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Clean press long enough to debounce, then clean release
  task automatic press(input int which);
    @(posedge clk); #1;
    case (which)
      0: bus.btn_pause_n = 1'b0;
      1: bus.btn_speed_n = 1'b0;
      default: bus.btn_mode_n = 1'b0;
    endcase
    repeat (DEB + 6) @(posedge clk);
    #1;
    bus.btn_pause_n = 1'b1;
    bus.btn_speed_n = 1'b1;
    bus.btn_mode_n  = 1'b1;
    repeat (DEB + 6) @(posedge clk);
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!rst && bus.cfg_update) begin
      exp_t e;
      n_cfg++;
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_cfg_update", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_offset", bus.offset, e.off);
        check_eq("sb_mode",   32'(bus.mode), 32'(e.mode));
        check_eq("sb_pal",    32'(bus.palette_rot), 32'(e.pal));
        check_eq("sb_speed",  32'(bus.speed), 32'(e.speed));
        check_eq("sb_paused", 32'(bus.paused), 32'(e.paused));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.btn_pause_n = 1'b1;
    bus.btn_speed_n = 1'b1;
    bus.btn_mode_n  = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Reset state, held with no frame_start
    repeat (20) @(posedge clk);
    check_now("reset");

    // Five plain frames: offset 1..5, palette 0,1,1,2,2
    for (int i = 0; i < 5; i++) do_frame();

    // Bouncing speed button: no event while bouncing
    repeat (5) begin
      @(posedge clk); #1 bus.btn_speed_n = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 bus.btn_speed_n = 1'b1;
      @(posedge clk);
    end
    do_frame();
    // Settle low: exactly one event, nothing changes until frame_start
    @(posedge clk); #1 bus.btn_speed_n = 1'b0;
    repeat (3 * DEB + 10) @(posedge clk);
    check_now("speed_prefs");
    #1 bus.btn_speed_n = 1'b1;
    repeat (DEB + 6) @(posedge clk);
    m_ps = 1;
    do_frame();
    do_frame();

    // Pause, three frozen frames, resume
    press(0); m_pp = 1;
    do_frame();
    for (int i = 0; i < 3; i++) do_frame();
    check_now("paused_hold");
    press(0); m_pp = 1;
    do_frame();

    // Mode event lands on the frame_start cycle: applied one frame later
    @(posedge clk); #1 bus.btn_mode_n = 1'b0;
    repeat (2 + DEB - 1) @(posedge clk);
    #1 bus.frame_start = 1'b1;
    model_step();
    @(posedge clk); #1 bus.frame_start = 1'b0;
    m_pm = 1;
    repeat (4) @(posedge clk);
    #1 bus.btn_mode_n = 1'b1;
    repeat (DEB + 6) @(posedge clk);
    do_frame();

    // Speed to 2, then preload offset near the 32-bit wrap
    press(1); m_ps = 1;
    do_frame();
    @(negedge clk);
    force dut.offset_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.offset_q;
    m_off = 32'hFFFF_FFFE;
    do_frame();

    // Run until palette_rot wraps 17 -> 0 at least once
    for (int i = 0; i < 2 * PENT + 4; i++) do_frame();

    // Async reset mid-frame with mode pending and button still held
    press(1); m_ps = 1;             // leaves a pending speed event in the DUT
    @(posedge clk); #1 bus.btn_mode_n = 1'b0;
    repeat (DEB + 6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("rst_async_offset", bus.offset, 32'd0);
    check_eq("rst_async_mode",   32'(bus.mode), 32'd0);
    check_eq("rst_async_pal",    32'(bus.palette_rot), 32'd0);
    check_eq("rst_async_speed",  32'(bus.speed), 32'd0);
    check_eq("rst_async_paused", 32'(bus.paused), 32'd0);
    check_eq("rst_async_cfgupd", 32'(bus.cfg_update), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    // Frame right after release: pending flags were discarded, new press not yet seen
    do_frame();
    repeat (DEB + 6) @(posedge clk);
    m_pm = 1;
    do_frame();
    #1 bus.btn_mode_n = 1'b1;
    repeat (DEB + 6) @(posedge clk);
    do_frame();
    check_now("final_hold");

    repeat (10) @(posedge clk);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("cfg_pulse_count", 32'(n_cfg), 32'(n_frames));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
